serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial ripple adder, LSB-first: one full-adder cell plus a carry flip-flop.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Computes one sum bit per clock and returns the WIDTH-bit sum and carry-out through a second valid/ready handshake.
- Addition counterpart of the combinational subtractor cells; used where area matters more than throughput.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 1..64)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b, cin valid
in_ready  output  1  block can accept operands
a  input  WIDTH  addend A (unsigned / two's complement)
b  input  WIDTH  addend B
cin  input  1  carry-in
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Reset:
  - Synchronous and active-high; wins over every other event.
  - Next state IDLE.
  - in_ready=1, out_valid=0, sum=0, cout=0; internal shift registers, carry and counter cleared.
- FSM IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0; go to RUN.
- FSM RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: {c, s} = full_add(a_sr[0], b_sr[0], carry).
  - sum_sr shifts right with s entering at MSB; a_sr and b_sr shift right; carry<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1: go to DONE.
  - This bit's sum and carry are written to sum/cout in the same edge.
- FSM DONE:
  - out_valid=1, in_ready=0; sum/cout held stable.
  - On out_ready: go to IDLE.
  - No operand accept in the same cycle as result handoff.
- Latency and throughput:
  - out_valid rises exactly WIDTH clock edges after the accepting edge.
  - Peak throughput is one operation per WIDTH+2 cycles.
- Operand sampling:
  - a, b and cin are sampled only on the accept edge.
  - Changes during RUN or DONE are ignored.
  - in_valid during RUN or DONE is not acknowledged; the producer must hold.
- Arithmetic:
  - Unsigned modulo 2^WIDTH; cout is the true carry.
  - Two's-complement correct for sum bits.
- Boundaries:
  - WIDTH=1: RUN lasts one cycle; the counter is at least 1 bit wide.
  - Carry chain wrap: all-ones + all-ones + 1 gives all-ones with cout=1.
  - Reset mid-RUN or in DONE: operation aborted, no result produced, outputs zeroed.
- sum/cout after consumption:
  - Reflect the last result until the next DONE.
  - Only meaningful while out_valid=1.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- When defined:
  - Extra output port ovf (1 bit).
  - ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), i.e. signed overflow.
  - Registered in the final RUN cycle and held with sum; reset value 0.
- When undefined: the port and its logic are absent; all other behaviour identical.

Decomposition:
- Shared package serial_adder_pkg:
  - State enum {IDLE, RUN, DONE}, 2-bit encoding.
  - Counter-width function max(1, clog2(WIDTH)).
- One sub-module, full_adder_bit:
  - Combinational; inputs x, y, ci; outputs s, co.
  - Instantiated once in the datapath.

Test Plan:
1. WIDTH=8, a=0x35, b=0x4A, cin=0, out_ready=1 -> sum=0x7F, cout=0; out_valid high exactly 8 edges after accept, for one cycle.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (OVF_EN: ovf=0). Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
3. a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Also WIDTH=1 build: a=1, b=1, cin=1 -> sum=1, cout=1, latency 1 edge.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/cout stable, in_ready=0, held in_valid not accepted; out_ready=1 -> IDLE next cycle, then new op accepted.
5. rst asserted during RUN after bit 3 of a=0xAA, b=0x55 -> next cycle in_ready=1, out_valid=0, sum=0; a following 0x10+0x20 gives sum=0x30, cout=0.
6. Change a and b every cycle during RUN -> result equals the operands captured on the accept edge.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Optional signed-overflow output is enabled by SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter needs at least one bit even for WIDTH=1.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// Single combinational full-adder cell.
// Used once per serial adder; carries ripple through a flip-flop.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder with valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             c;
    logic             accept;
    logic             last;

    full_adder_bit u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry),
        .s  (s),
        .co (c)
    );

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last      = (cnt == CW'(WIDTH - 1));
        // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        sum_nx    = (sum_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sr  <= a;
                b_sr  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                sum_sr <= sum_nx;
                carry  <= c;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    sum  <= sum_nx;
                    cout <= c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry still holds the carry into the MSB here.
                    ovf  <= carry ^ c;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances).
// Covers ovf when built with SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         in_valid1;
    logic         in_ready1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         cin1;
    logic         out_valid1;
    logic         out_ready1;
    logic [0:0]   sum1;
    logic         cout1;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
    logic         ovf1;
`endif

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         v;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic ci);
        logic [W:0] t;
        exp_t       e;
        t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s  = t[W-1:0];
        e.co = t[W];
        e.v  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input exp_t e, input bit push);
        int n = 0;
        a        = x;
        b        = y;
        cin      = ci;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 64'(n), 64'(0));
        @(posedge clk);
        if (push) sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Scrambles operands while running to prove they are ignored.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(W));
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            e = sbq.pop_front();
            chk({tag, "_sum"}, 64'(sum), 64'(e.s));
            chk({tag, "_cout"}, 64'(cout), 64'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
            chk({tag, "_ovf"}, 64'(ovf), 64'(e.v));
`endif
        end
    endtask

    task automatic wait_result(input string tag);
        int lat;
        wait_valid(lat);
        check_result(tag);
        @(negedge clk);
        chk({tag, "_one_cycle"}, 64'(out_valid), 64'(0));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        e    = model(v.a, v.b, v.cin);
        e.s  = v.s;
        e.co = v.co;
        accept(v.a, v.b, v.cin, e, 1'b1);
        wait_result(tag);
    endtask

    vec_t tbl[10];

    initial begin
        int   lat;
        exp_t e;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         ci;

        tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        tbl[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[7] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
        tbl[8] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        tbl[9] = '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1};

        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        a1         = '0;
        b1         = '0;
        cin1       = 1'b0;
        out_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            x  = W'($urandom);
            y  = W'($urandom);
            ci = 1'($urandom);
            e  = model(x, y, ci);
            accept(x, y, ci, e, 1'b1);
            wait_result($sformatf("rnd%0d", i));
        end

        // Backpressure: result held while consumer stalls, held input ignored.
        out_ready = 1'b0;
        accept(8'h12, 8'h34, 1'b0, model(8'h12, 8'h34, 1'b0), 1'b1);
        wait_valid(lat);
        check_result("bp");
        a        = 8'h01;
        b        = 8'h02;
        cin      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid), 64'(1));
            chk("bp_hold_ready", 64'(in_ready), 64'(0));
            chk("bp_hold_sum", 64'(sum), 64'(8'h46));
            chk("bp_hold_cout", 64'(cout), 64'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_ready", 64'(in_ready), 64'(1));
        chk("bp_idle_valid", 64'(out_valid), 64'(0));
        accept(8'h01, 8'h02, 1'b1, model(8'h01, 8'h02, 1'b1), 1'b1);
        wait_result("bp_next");

        // Reset mid-run aborts the operation and zeroes the outputs.
        accept(8'hAA, 8'h55, 1'b0, model(8'hAA, 8'h55, 1'b0), 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_sum", 64'(sum), 64'(0));
        chk("abort_cout", 64'(cout), 64'(0));
        run_vec(tbl[5], "post_abort");

        // WIDTH=1 instance: one RUN cycle.
        chk("w1_in_ready", 64'(in_ready1), 64'(1));
        in_valid1 = 1'b1;
        a1        = 1'b1;
        b1        = 1'b1;
        cin1      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("w1_latency", 64'(lat), 64'(1));
        chk("w1_sum", 64'(sum1), 64'(1));
        chk("w1_cout", 64'(cout1), 64'(1));
`ifdef SERIAL_ADDER_OVF_EN
        chk("w1_ovf", 64'(ovf1), 64'(0));
`endif
        @(negedge clk);
        chk("w1_one_cycle", 64'(out_valid1), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
